// File: rtl/seq_pkg.sv
// Shared types for the multi-cycle sequencer: state encoding, opcodes,
// ALU function codes and the registered control word.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4;
    localparam logic [3:0] OP_BNE = 4'd5;
    localparam logic [3:0] OP_LW  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_CMP = 3'b101;

    typedef struct packed {
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_we;
        logic       branch;
        logic [2:0] alu_op;
        logic       alu_src;
    } ctl_t;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decode into a control word; legal is low for
// opcodes 8-15, which decode to an all-zero (NOP) control word.
module op_decoder
    import seq_pkg::*;
(
    input  logic [3:0] opcode,
    output ctl_t       ctl,
    output logic       legal
);

    always_comb begin
        ctl   = '0;
        legal = 1'b1;
        case (opcode)
            OP_ADD: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.alu_op    = ALU_ADD;
            end
            OP_SUB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.alu_op    = ALU_SUB;
            end
            OP_AND: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.alu_op    = ALU_AND;
            end
            OP_OR: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.alu_op    = ALU_OR;
            end
            OP_SLT: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.alu_op    = ALU_SLT;
            end
            OP_BNE: begin
                ctl.branch = 1'b1;
                ctl.alu_op = ALU_CMP;
            end
            OP_LW: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
                ctl.alu_op     = ALU_ADD;
                ctl.alu_src    = 1'b1;
            end
            OP_SW: begin
                ctl.mem_we  = 1'b1;
                ctl.alu_op  = ALU_ADD;
                ctl.alu_src = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout.
// Define SEQ_ILLEGAL_TRAP_EN to trap opcodes 8-15 and expose the sticky illegal flag.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int WAIT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_branch,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       mem_timeout
`ifdef SEQ_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_MAX - WAIT_W'(1);

    state_t            state_q, state_d;
    ctl_t              ctl_q, ctl_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    ctl_t              dec_ctl;
    logic              dec_legal;
    state_t            boundary;
    logic              wait_hit;

    op_decoder u_op_decoder (
        .opcode (opcode),
        .ctl    (dec_ctl),
        .legal  (dec_legal)
    );

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal = illegal_q;
`endif

    assign boundary = run ? FETCH : IDLE;
    // The wait cycle that would bring the counter to WAIT_MAX aborts the access.
    assign wait_hit = (wait_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        ctl_d       = ctl_q;
        wait_d      = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_branch   = 1'b0;
        reg_write   = 1'b0;
        instr_done  = 1'b0;
        mem_timeout = 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (wait_hit) begin
                    mem_timeout = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DECODE: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                if (dec_legal) begin
                    ctl_d   = dec_ctl;
                    state_d = EXEC;
                end else begin
                    ctl_d     = '0;
                    illegal_d = 1'b1;
                    state_d   = TRAP;
                end
`else
                ctl_d   = dec_legal ? dec_ctl : '0;
                state_d = EXEC;
`endif
            end
            EXEC: begin
                if (ctl_q.branch) begin
                    pc_branch  = ~zero;
                    instr_done = 1'b1;
                    state_d    = boundary;
                end else if (ctl_q.mem_we || ctl_q.mem_to_reg) begin
                    state_d = MEM;
                end else if (ctl_q.reg_write) begin
                    state_d = WB;
                end else begin
                    // Zero control word: NOP retires here without any strobe.
                    instr_done = 1'b1;
                    state_d    = boundary;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = ctl_q.mem_we;
                if (mem_ready) begin
                    if (ctl_q.mem_to_reg) begin
                        state_d = WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = boundary;
                    end
                end else if (wait_hit) begin
                    mem_timeout = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = boundary;
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            TRAP: begin
                state_d = TRAP;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ctl_q   <= '0;
            wait_q  <= '0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            wait_q  <= wait_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign reg_dst    = ctl_q.reg_dst;
    assign mem_to_reg = ctl_q.mem_to_reg;
    assign alu_src    = ctl_q.alu_src;
    assign alu_op     = ctl_q.alu_op;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed table-driven bench for multicycle_sequencer plus hand-written
// corner sequences (opcode 9, memory timeout, reset during MEM).
module tb_multicycle_sequencer;

    localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SX = 3'd3,
                           SM = 3'd4, SW = 3'd5, ST = 3'd6;

    logic       clk, reset, run, zero, mem_ready;
    logic [3:0] opcode;
    logic       mem_req, mem_we, ir_write, pc_write, pc_branch, reg_write;
    logic       reg_dst, mem_to_reg, alu_src, instr_done, mem_timeout;
    logic [2:0] alu_op, state;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_sequencer #(.WAIT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_branch   (pc_branch),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .state       (state),
        .instr_done  (instr_done),
        .mem_timeout (mem_timeout)
`ifdef SEQ_ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        run;
        logic [3:0]  op;
        logic        zero;
        logic        mr;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl [30];

    // Expected output word: {state, mem_req, mem_we, ir_write, pc_write, pc_branch,
    // reg_write, reg_dst, mem_to_reg, alu_src, alu_op, instr_done, mem_timeout}
    function automatic logic [16:0] ov(input logic [2:0] st, input logic mreq, mwe, irw, pcw,
                                       pcb, rw, rdst, m2r, asrc, input logic [2:0] aop,
                                       input logic done, tmo);
        return {st, mreq, mwe, irw, pcw, pcb, rw, rdst, m2r, asrc, aop, done, tmo};
    endfunction

    function automatic vec_t mkv(input logic rn, input logic [3:0] op, input logic z,
                                 input logic mr, input logic [16:0] e);
        return vec_t'({rn, op, z, mr, e});
    endfunction

    task automatic apply(input logic r, input logic rn, input logic [3:0] op, input logic z,
                         input logic mr, input logic [16:0] exp, input string name);
        logic [16:0] act;
        @(negedge clk);
        reset = r; run = rn; opcode = op; zero = z; mem_ready = mr;
        #1;
        act = {state, mem_req, mem_we, ir_write, pc_write, pc_branch, reg_write,
               reg_dst, mem_to_reg, alu_src, alu_op, instr_done, mem_timeout};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

`ifdef SEQ_ILLEGAL_TRAP_EN
    task automatic check_illegal(input logic exp, input string name);
        n_tests++;
        if (illegal !== exp) begin
            n_fail++;
            $display("FAIL %s: illegal got %b expected %b", name, illegal, exp);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; run = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;

        // ADD, SUB back-to-back; BNE taken and not taken; LW with 3 waits; SW with fetch wait
        tbl[0]  = mkv(1, 0, 0, 1, ov(SI, 0,0,0,0,0,0, 0,0,0, 3'd0, 0,0));
        tbl[1]  = mkv(1, 0, 0, 1, ov(SF, 1,0,1,1,0,0, 0,0,0, 3'd0, 0,0));
        tbl[2]  = mkv(1, 0, 0, 1, ov(SD, 0,0,0,0,0,0, 0,0,0, 3'd0, 0,0));
        tbl[3]  = mkv(1, 0, 0, 1, ov(SX, 0,0,0,0,0,0, 1,0,0, 3'd0, 0,0));
        tbl[4]  = mkv(1, 0, 0, 1, ov(SW, 0,0,0,0,0,1, 1,0,0, 3'd0, 1,0));
        tbl[5]  = mkv(1, 1, 0, 1, ov(SF, 1,0,1,1,0,0, 1,0,0, 3'd0, 0,0));
        tbl[6]  = mkv(1, 1, 0, 1, ov(SD, 0,0,0,0,0,0, 1,0,0, 3'd0, 0,0));
        tbl[7]  = mkv(1, 1, 0, 1, ov(SX, 0,0,0,0,0,0, 1,0,0, 3'd1, 0,0));
        tbl[8]  = mkv(1, 1, 0, 1, ov(SW, 0,0,0,0,0,1, 1,0,0, 3'd1, 1,0));
        tbl[9]  = mkv(1, 5, 0, 1, ov(SF, 1,0,1,1,0,0, 1,0,0, 3'd1, 0,0));
        tbl[10] = mkv(1, 5, 0, 1, ov(SD, 0,0,0,0,0,0, 1,0,0, 3'd1, 0,0));
        tbl[11] = mkv(1, 5, 0, 1, ov(SX, 0,0,0,0,1,0, 0,0,0, 3'd5, 1,0));
        tbl[12] = mkv(1, 5, 1, 1, ov(SF, 1,0,1,1,0,0, 0,0,0, 3'd5, 0,0));
        tbl[13] = mkv(1, 5, 1, 1, ov(SD, 0,0,0,0,0,0, 0,0,0, 3'd5, 0,0));
        tbl[14] = mkv(1, 5, 1, 1, ov(SX, 0,0,0,0,0,0, 0,0,0, 3'd5, 1,0));
        tbl[15] = mkv(1, 6, 0, 1, ov(SF, 1,0,1,1,0,0, 0,0,0, 3'd5, 0,0));
        tbl[16] = mkv(1, 6, 0, 1, ov(SD, 0,0,0,0,0,0, 0,0,0, 3'd5, 0,0));
        tbl[17] = mkv(1, 6, 0, 1, ov(SX, 0,0,0,0,0,0, 0,1,1, 3'd0, 0,0));
        tbl[18] = mkv(1, 6, 0, 0, ov(SM, 1,0,0,0,0,0, 0,1,1, 3'd0, 0,0));
        tbl[19] = mkv(1, 6, 0, 0, ov(SM, 1,0,0,0,0,0, 0,1,1, 3'd0, 0,0));
        tbl[20] = mkv(1, 6, 0, 0, ov(SM, 1,0,0,0,0,0, 0,1,1, 3'd0, 0,0));
        tbl[21] = mkv(1, 6, 0, 1, ov(SM, 1,0,0,0,0,0, 0,1,1, 3'd0, 0,0));
        tbl[22] = mkv(1, 6, 0, 1, ov(SW, 0,0,0,0,0,1, 0,1,1, 3'd0, 1,0));
        tbl[23] = mkv(1, 7, 0, 0, ov(SF, 1,0,0,0,0,0, 0,1,1, 3'd0, 0,0));
        tbl[24] = mkv(1, 7, 0, 1, ov(SF, 1,0,1,1,0,0, 0,1,1, 3'd0, 0,0));
        tbl[25] = mkv(1, 7, 0, 1, ov(SD, 0,0,0,0,0,0, 0,1,1, 3'd0, 0,0));
        tbl[26] = mkv(1, 7, 0, 1, ov(SX, 0,0,0,0,0,0, 0,0,1, 3'd0, 0,0));
        tbl[27] = mkv(0, 7, 0, 1, ov(SM, 1,1,0,0,0,0, 0,0,1, 3'd0, 1,0));
        tbl[28] = mkv(0, 7, 0, 1, ov(SI, 0,0,0,0,0,0, 0,0,1, 3'd0, 0,0));
        tbl[29] = mkv(0, 7, 0, 1, ov(SI, 0,0,0,0,0,0, 0,0,1, 3'd0, 0,0));

        apply(1, 0, 4'd0, 0, 0, 17'd0, "reset_a");
        apply(1, 0, 4'd0, 0, 1, 17'd0, "reset_b");
`ifdef SEQ_ILLEGAL_TRAP_EN
        check_illegal(1'b0, "reset_illegal");
`endif

        for (int i = 0; i < 30; i++)
            apply(0, tbl[i].run, tbl[i].op, tbl[i].zero, tbl[i].mr, tbl[i].exp,
                  $sformatf("row%0d", i));

        // Opcode 9; run drops during DECODE
        apply(0, 1, 4'd9, 0, 1, ov(SI, 0,0,0,0,0,0, 0,0,1, 3'd0, 0,0), "op9_idle");
        apply(0, 1, 4'd9, 0, 1, ov(SF, 1,0,1,1,0,0, 0,0,1, 3'd0, 0,0), "op9_fetch");
        apply(0, 0, 4'd9, 0, 1, ov(SD, 0,0,0,0,0,0, 0,0,1, 3'd0, 0,0), "op9_decode");
`ifdef SEQ_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            apply(0, 1, 4'd9, 0, 1, ov(ST, 0,0,0,0,0,0, 0,0,0, 3'd0, 0,0), $sformatf("trap_hold%0d", k));
            check_illegal(1'b1, $sformatf("trap_illegal%0d", k));
        end
        apply(1, 0, 4'd0, 0, 0, ov(ST, 0,0,0,0,0,0, 0,0,0, 3'd0, 0,0), "trap_rst");
        apply(0, 0, 4'd0, 0, 0, 17'd0, "trap_cleared");
        check_illegal(1'b0, "trap_illegal_clr");
`else
        apply(0, 0, 4'd9, 0, 1, ov(SX, 0,0,0,0,0,0, 0,0,0, 3'd0, 1,0), "nop_exec");
        apply(0, 0, 4'd9, 0, 1, ov(SI, 0,0,0,0,0,0, 0,0,0, 3'd0, 0,0), "nop_idle");
`endif

        // SW whose memory never answers: 15 wait cycles, pulse on the 15th
        apply(0, 1, 4'd7, 0, 1, ov(SI, 0,0,0,0,0,0, 0,0,0, 3'd0, 0,0), "to_idle");
        apply(0, 1, 4'd7, 0, 1, ov(SF, 1,0,1,1,0,0, 0,0,0, 3'd0, 0,0), "to_fetch");
        apply(0, 1, 4'd7, 0, 1, ov(SD, 0,0,0,0,0,0, 0,0,0, 3'd0, 0,0), "to_decode");
        apply(0, 1, 4'd7, 0, 1, ov(SX, 0,0,0,0,0,0, 0,0,1, 3'd0, 0,0), "to_exec");
        for (int k = 1; k <= 14; k++)
            apply(0, 0, 4'd7, 0, 0, ov(SM, 1,1,0,0,0,0, 0,0,1, 3'd0, 0,0), $sformatf("to_wait%0d", k));
        apply(0, 0, 4'd7, 0, 0, ov(SM, 1,1,0,0,0,0, 0,0,1, 3'd0, 0,1), "to_pulse");
        apply(0, 0, 4'd7, 0, 1, ov(SI, 0,0,0,0,0,0, 0,0,1, 3'd0, 0,0), "to_after");

        // Reset while SW is waiting in MEM
        apply(0, 1, 4'd7, 0, 1, ov(SI, 0,0,0,0,0,0, 0,0,1, 3'd0, 0,0), "rst_idle");
        apply(0, 1, 4'd7, 0, 1, ov(SF, 1,0,1,1,0,0, 0,0,1, 3'd0, 0,0), "rst_fetch");
        apply(0, 1, 4'd7, 0, 1, ov(SD, 0,0,0,0,0,0, 0,0,1, 3'd0, 0,0), "rst_decode");
        apply(0, 1, 4'd7, 0, 1, ov(SX, 0,0,0,0,0,0, 0,0,1, 3'd0, 0,0), "rst_exec");
        apply(0, 1, 4'd7, 0, 0, ov(SM, 1,1,0,0,0,0, 0,0,1, 3'd0, 0,0), "rst_mem");
        apply(1, 1, 4'd7, 0, 0, ov(SM, 1,1,0,0,0,0, 0,0,1, 3'd0, 0,0), "rst_mem_edge");
        apply(0, 0, 4'd7, 0, 1, 17'd0, "rst_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle sequencer for the 16-bit processor: it steps each instruction through fetch, decode, execute, memory and write-back. Each step drives the register-file, ALU, memory and PC strobes from a registered decode of the 4-bit opcode. It sits between the instruction register and the datapath and replaces single-cycle use of the combinational decode. A valid/ready memory handshake lets it stall on slow memory, and a bounded wait aborts a hung access.

## Interface
- WAIT_W, 4: width of the memory-wait counter; timeout after 2^WAIT_W-1 cycles without mem_ready.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level enable; when low, sequencer parks in IDLE at the next instruction boundary.
- opcode  in  4  IR[15:12]; sampled in DECODE.
- zero  in  1  ALU zero flag; used in EXEC for BNE.
- mem_ready  in  1  memory acknowledge; accepted in the same cycle as mem_req.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier; valid only with mem_req.
- ir_write  out  1  load IR from memory data.
- pc_write  out  1  PC <= PC+1.
- pc_branch  out  1  PC <= branch target.
- reg_write  out  1  register-file write strobe.
- reg_dst  out  1  1 = write rC, 0 = write rB.
- mem_to_reg  out  1  1 = write-back from memory, 0 = from ALU.
- alu_src  out  1  1 = immediate operand.
- alu_op  out  3  ALU function.
- state  out  3  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- mem_timeout  out  1  one-cycle pulse on an aborted access.
- illegal  out  1  sticky illegal-opcode flag; present only with SEQ_ILLEGAL_TRAP_EN.

## Operation
- Opcode mapping:
  - 0-4 (ADD/SUB/AND/OR/SLT): reg_dst=1, reg_write, alu_op=opcode, alu_src=0.
  - 5 (BNE): alu_op=101, alu_src=0.
  - 6 (LW): mem_to_reg=1, reg_write, alu_op=000, alu_src=1.
  - 7 (SW): mem_we, alu_op=000, alu_src=1.
- DECODE latches the control word into the ctl register. All datapath outputs except the strobes come from ctl.
- States and transitions:
  - IDLE: goes to FETCH when run=1.
  - FETCH: mem_req=1, mem_we=0. On mem_ready, ir_write=1 and pc_write=1 in that cycle, then DECODE.
  - DECODE: ctl <= decode(opcode), then EXEC.
  - EXEC: alu_op and alu_src driven. Opcodes 0-4 go to WB. For BNE, pc_branch=~zero, instr_done=1, then done. LW/SW go to MEM.
  - MEM: mem_req=1, mem_we=ctl.mem_we. On mem_ready, SW asserts instr_done and goes to done; LW goes to WB.
  - WB: reg_write=1 for exactly one cycle with reg_dst and mem_to_reg from ctl; instr_done=1, then done.
  - "done" means next state FETCH if run=1, else IDLE.
- Wait counter:
  - Clears on entry to FETCH or MEM and counts while mem_req=1 and mem_ready=0.
  - At 2^WAIT_W-1 it pulses mem_timeout and goes to IDLE. Nothing is written, and pc_write stays 0.
- Strobes (mem_req, ir_write, pc_write, pc_branch, reg_write, instr_done) are decoded from state; they are never registered copies.
- Opcodes 8-15 without the macro: treated as NOP. EXEC asserts instr_done and goes to done; no strobes fire.

## Timing
- Reset values: state=IDLE, ctl=0, wait counter=0, every output 0.
- Reset mid-instruction: the access is abandoned; all strobes read 0 in the first cycle after the reset edge.
- Latency with zero-wait memory:
  - R-type: 4 cycles (FETCH, DECODE, EXEC, WB).
  - BNE: 3 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each memory wait cycle adds 1.
- run=0 mid-instruction: the instruction completes; the sequencer stops at the boundary.
- mem_ready outside FETCH/MEM is ignored.
- Back-to-back: the FETCH of the next instruction occupies the cycle immediately after instr_done.

## Configuration
- SEQ_ILLEGAL_TRAP_EN defined:
  - DECODE of opcodes 8-15 goes to TRAP and sets illegal=1.
  - TRAP holds with all strobes 0 until reset; illegal is cleared only by reset.
- SEQ_ILLEGAL_TRAP_EN undefined: no TRAP state and no illegal port; opcodes 8-15 behave as the NOP described in Operation.

## Structure
- Package seq_pkg holds:
  - the state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - opcode constants OP_ADD..OP_SW.
  - the ALU function constants.
  - the ctl_t packed struct with fields reg_dst, mem_to_reg, reg_write, mem_we, branch, alu_op[2:0], alu_src.
- One sub-module, op_decoder: purely combinational opcode -> ctl_t plus a legal flag. The sequencer FSM, wait counter and ctl register stay in the top module.

## Test plan
- Reset, run=1, opcode=0 (ADD), mem_ready=1 -> ir_write and pc_write in cycle 1, alu_op=000 in cycle 3, reg_write=1 with reg_dst=1 in cycle 4 only, instr_done in cycle 4.
- BNE with zero=0, then BNE with zero=1 -> pc_branch=1 in EXEC for the first and 0 for the second; each completes in 3 cycles.
- LW with mem_ready delayed 3 cycles in MEM -> mem_req held for 4 cycles, then reg_write=1 with mem_to_reg=1; total 8 cycles.
- SW with WAIT_W=4 and mem_ready never asserted -> mem_timeout pulses after 15 wait cycles, state=IDLE, reg_write never asserted.
- Reset asserted during MEM of SW -> all outputs 0 in the next cycle, state=IDLE.
- Opcode 9 -> with the macro: illegal=1, state=TRAP, held until reset. Without the macro: instr_done in EXEC and no strobes.
